// File: rtl/inst_mem_responder_pkg.sv
// inst_mem_responder_pkg: shared widths, constants and fault-reason encoding
package inst_mem_responder_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  localparam logic ENABLE = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic [31:0] NOP_INST = 32'h0;
  typedef enum logic [1:0] {
    FAULT_NONE,
    FAULT_MISALIGNED,
    FAULT_RANGE
  } fault_reason_t;
endpackage

// File: rtl/inst_mem_responder_delay_line.sv
// resp_delay_line: clearable shift register of response payloads, STAGES deep (0 = wire)
module resp_delay_line #(
  parameter int STAGES = 1,
  parameter int W = 8
)(
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (STAGES == 0) begin : g_pass
    assign q = d;
  end else begin : g_sr
    logic [W-1:0] sr [STAGES];
    always_ff @(posedge clk)
      if (rst) for (int i = 0; i < STAGES; i++) sr[i] <= '0;
      else begin
        sr[0] <= d;
        for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
      end
    assign q = sr[STAGES-1];
  end
endmodule

// File: rtl/inst_mem_responder.sv
// inst_mem_responder: fixed-latency instruction memory with program-load write port
module inst_mem_responder import inst_mem_responder_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY = 2
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  inst_valid,
  output logic [ADDR_WIDTH-1:0] inst_addr,
  output logic                  fault,
  output logic [31:0]           fetch_count
);
  localparam int PW = 2 + ADDR_WIDTH + DATA_WIDTH;
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;
  logic rd_bad, wr_ok;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [PW-1:0] s1, resp;
  assign rd_idx = addr[DEPTH_LOG2+1:2];
  assign wr_idx = wr_addr[DEPTH_LOG2+1:2];
  assign rd_bad = |addr[1:0] || |addr[ADDR_WIDTH-1:DEPTH_LOG2+2];
  assign wr_ok = wr_en && ~|wr_addr[1:0] && ~|wr_addr[ADDR_WIDTH-1:DEPTH_LOG2+2];
  // write-first: a same-cycle write to the fetched word is forwarded
  assign rd_data = rd_bad ? DATA_WIDTH'(NOP_INST) : (wr_ok && wr_idx == rd_idx) ? wr_data : mem[rd_idx];
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_idx] <= wr_data;
  always_ff @(posedge clk)
    if (rst || ce == DISABLE) s1 <= '0;
    else s1 <= {ENABLE, rd_bad, addr, rd_data};
  resp_delay_line #(.STAGES(LATENCY-1), .W(PW)) u_delay (
    .clk(clk),
    .rst(rst),
    .d(s1),
    .q(resp)
  );
  assign {inst_valid, fault, inst_addr, inst} = resp;
  always_ff @(posedge clk)
    if (rst) fetch_count <= ZERO_WORD;
    else fetch_count <= fetch_count + 32'(inst_valid);
endmodule

// File: tb/tb_inst_mem_responder.sv
// tb_inst_mem_responder: scoreboard bench over LATENCY=2/1/4 instances sharing one stimulus stream
module tb_inst_mem_responder;
  typedef struct {
    int acc;
    logic v, f;
    logic [31:0] a, d;
  } exp_t;
  localparam int LAT [3] = '{2, 1, 4};
  logic clk = 0, rst = 1, ce = 0, wr_en = 0;
  logic [31:0] addr = 0, wr_addr = 0, wr_data = 0;
  logic [2:0] v, f;
  logic [2:0][31:0] a, d, fc;
  logic [31:0] mem_m [1024];
  exp_t q[$];
  exp_t e;
  int ptr [3] = '{0, 0, 0};
  int cnt [3] = '{0, 0, 0};
  int cyc = 0, checks = 0, errors = 0;
  bit armed = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  inst_mem_responder #(.LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .ce(ce), .addr(addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .inst(d[0]), .inst_valid(v[0]), .inst_addr(a[0]),
    .fault(f[0]), .fetch_count(fc[0]));
  inst_mem_responder #(.LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .ce(ce), .addr(addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .inst(d[1]), .inst_valid(v[1]), .inst_addr(a[1]),
    .fault(f[1]), .fetch_count(fc[1]));
  inst_mem_responder #(.LATENCY(4)) u_l4 (.clk(clk), .rst(rst), .ce(ce), .addr(addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .inst(d[2]), .inst_valid(v[2]), .inst_addr(a[2]),
    .fault(f[2]), .fetch_count(fc[2]));
  // each instance consumes the shared expectation stream at its own latency
  always @(negedge clk)
    if (armed)
      for (int k = 0; k < 3; k++) begin
        logic hit;
        hit = 0;
        checks++;
        if (ptr[k] < q.size() && q[ptr[k]].acc + LAT[k] - 1 == cyc) begin
          e = q[ptr[k]];
          ptr[k]++;
          hit = e.v;
          if ({v[k], f[k], a[k], d[k]} !== {e.v, e.f, e.a, e.d}) begin
            errors++;
            $display("FAIL resp L=%0d cyc=%0d got v=%b f=%b a=%h d=%h want v=%b f=%b a=%h d=%h",
              LAT[k], cyc, v[k], f[k], a[k], d[k], e.v, e.f, e.a, e.d);
          end
        end else if ({v[k], f[k], a[k], d[k]} !== '0) begin
          errors++;
          $display("FAIL idle L=%0d cyc=%0d got v=%b f=%b a=%h d=%h want all zero",
            LAT[k], cyc, v[k], f[k], a[k], d[k]);
        end
        checks++;
        if (fc[k] !== cnt[k]) begin
          errors++;
          $display("FAIL fetch_count L=%0d cyc=%0d got %0d want %0d", LAT[k], cyc, fc[k], cnt[k]);
        end
        if (hit) cnt[k]++;
      end
  task automatic step(input logic r, input logic c, input logic [31:0] ad,
                      input logic w = 0, input logic [31:0] wa = 0, input logic [31:0] wd = 0);
    exp_t x;
    logic bad, wok;
    bad = ad[1:0] != 0 || ad[31:12] != 0;
    wok = w && wa[1:0] == 0 && wa[31:12] == 0;
    rst = r; ce = c; addr = ad; wr_en = w; wr_addr = wa; wr_data = wd;
    if (!r) begin
      x.acc = cyc + 1;
      x.v = c;
      x.f = c && bad;
      x.a = c ? ad : 32'h0;
      x.d = (c && !bad) ? ((wok && wa[11:2] == ad[11:2]) ? wd : mem_m[ad[11:2]]) : 32'h0;
      q.push_back(x);
    end
    if (wok) mem_m[wa[11:2]] = wd;
    @(posedge clk); #1;
    if (r) begin
      q.delete();
      ptr = '{0, 0, 0};
      cnt = '{0, 0, 0};
      armed = 1;
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0);
  endtask
  task automatic test_reset;
    step(1, 0, 32'h0);
    step(1, 1, 32'h0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({v[k], f[k], a[k], d[k], fc[k]} !== '0) begin
        errors++;
        $display("FAIL reset_state L=%0d got v=%b f=%b a=%h d=%h fc=%0d want all zero",
          LAT[k], v[k], f[k], a[k], d[k], fc[k]);
      end
    end
  endtask
  task automatic check_count(input string name, input logic [31:0] want);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (fc[k] !== want) begin
        errors++;
        $display("FAIL %s L=%0d fetch_count got %0d want %0d", name, LAT[k], fc[k], want);
      end
    end
  endtask
  task automatic test_basic;
    step(0, 0, 32'h0, 1, 32'h0, 32'h11111111);
    step(0, 0, 32'h0, 1, 32'h4, 32'h22222222);
    step(0, 0, 32'h0, 1, 32'h8, 32'h33333333);
    step(0, 0, 32'h0, 1, 32'h2, 32'hBAD0BAD0);
    step(0, 0, 32'h0, 1, 32'h1008, 32'hBAD1BAD1);
    step(0, 1, 32'h0);
    step(0, 1, 32'h4);
    step(0, 1, 32'h8);
    idle(5);
    check_count("basic_count", 3);
  endtask
  task automatic test_bubble;
    step(0, 1, 32'h4);
    step(0, 0, 32'h123);
    step(0, 1, 32'h8);
    idle(5);
    check_count("bubble_count", 5);
  endtask
  task automatic test_fault;
    step(0, 1, 32'h6);
    step(0, 1, 32'h00001000);
    idle(5);
    check_count("fault_count", 7);
  endtask
  task automatic test_write_first;
    step(0, 1, 32'h4, 1, 32'h4, 32'hDEADBEEF);
    step(0, 1, 32'h4);
    idle(5);
    check_count("write_first_count", 9);
  endtask
  task automatic test_reset_midflight;
    step(0, 1, 32'h0);
    step(0, 1, 32'h4);
    step(0, 1, 32'h8);
    step(1, 0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (v !== 3'b000 || fc !== '0) begin
        errors++;
        $display("FAIL midflight_reset cyc=%0d valid got %b want 000 fc got %h want 0", cyc, v, fc);
      end
      step(0, 0, 32'h0);
    end
    step(0, 1, 32'h0);
    idle(5);
    check_count("retained_count", 1);
  endtask
  task automatic test_latency_sweep;
    int seen [3];
    seen = '{0, 0, 0};
    step(0, 1, 32'h8);
    for (int n = 1; n <= 8; n++) begin
      for (int k = 0; k < 3; k++)
        if (v[k] === 1'b1 && seen[k] == 0) seen[k] = n;
      step(0, 0, 32'h0);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (seen[k] != LAT[k]) begin
        errors++;
        $display("FAIL latency L=%0d valid after %0d edges want %0d", LAT[k], seen[k], LAT[k]);
      end
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_bubble;
    test_fault;
    test_write_first;
    test_reset_midflight;
    test_latency_sweep;
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
